// File: rtl/mult_scheduler_pkg.sv
// Shared constants and types for the multiplier scheduler and its arbiter.
package mult_sched_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PROD_WIDTH_DEF = 2 * DATA_WIDTH_DEF;
    localparam int WD_LIMIT       = 16;
    localparam int WD_W           = $clog2(WD_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_HI     = 3'd4,
        S_RSP    = 3'd5
    } sched_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has top priority.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_valid
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sel;
    logic            hit;

    always_comb begin
        cand = '0;
        sel  = '0;
        hit  = 1'b0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        gnt_valid = en && hit;
        gnt_idx   = sel;
        gnt       = gnt_valid ? (NUM_REQ'(1) << sel) : '0;
        ptr_d     = ptr_q;
        if (gnt_valid) begin
            ptr_d = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one serial shift-and-add multiplier among NUM_REQ requesters and
// returns each 16-bit product with the id of the requester that issued it.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_product,
    output logic                          mul_start,
    output logic [DATA_WIDTH-1:0]         mul_data,
    input  logic                          mul_done,
    input  logic                          mul_lsb_out,
    input  logic                          mul_msb_out,
    input  logic [DATA_WIDTH-1:0]         mul_result
);

    sched_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  start_q, start_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic                  grant_en;
    logic                  gnt_valid;
    logic [ID_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]    gnt;

    // Grant only when idle and the multiplier itself is idle.
    assign grant_en = (state_q == S_IDLE) && mul_done && !i_rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .req       (req_valid),
        .en        (grant_en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        opb_d       = opb_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        id_d        = id_q;
        wd_d        = wd_q;
        start_d     = 1'b0;
        data_d      = '0;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    state_d = S_LOAD_A;
                    id_d    = gnt_idx;
                    opb_d   = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    data_d  = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    start_d = 1'b1;
                end
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
                data_d  = opb_q;
            end
            S_LOAD_B: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (mul_lsb_out) begin
                    lo_d    = mul_result;
                    state_d = S_HI;
                end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_HI: begin
                wd_d = wd_q + WD_W'(1);
                if (mul_msb_out) begin
                    hi_d        = mul_result;
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_RSP: begin
                rsp_valid_d = !rsp_ready;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            opb_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            id_q        <= '0;
            wd_q        <= '0;
            start_q     <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opb_q       <= opb_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            id_q        <= id_d;
            wd_q        <= wd_d;
            start_q     <= start_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready   = gnt;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = {hi_q, lo_q};
    assign mul_start   = start_q;
    assign mul_data    = data_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed and randomized bench for mult_scheduler with a serial multiplier
// model and a round-robin / arithmetic reference.
module tb_mult_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [N-1:0] vld;
    logic [7:0]   opa [N];
    logic [7:0]   opb [N];
    logic [N*8-1:0] req_a, req_b;
    logic [N-1:0] req_ready;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [15:0]  rsp_product;
    logic         mul_start;
    logic [7:0]   mul_data;
    logic         mul_done, mul_lsb_out, mul_msb_out;
    logic [7:0]   mul_result;

    int           ph = 0;
    logic [7:0]   ma, mb;
    logic [15:0]  mp;
    bit           stuck, spur_lsb, spur_msb, refill;
    logic [7:0]   spur_res = 8'h5A;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_grant = 0;
    int exp_gap = 0;
    int rr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = opa[i];
            req_b[i*8 +: 8] = opb[i];
        end
    end

    // Serial multiplier: A with start, B next cycle, low byte 10 cycles
    // after start, high byte one later, idle again the cycle after that.
    always @(posedge clk) begin
        if (ph == 0) begin
            if (mul_start) begin
                ph <= 1;
                ma <= mul_data;
            end
        end else begin
            if (ph == 1) mb <= mul_data;
            ph <= (ph == 11) ? 0 : ph + 1;
        end
    end

    assign mp          = 16'(ma) * 16'(mb);
    assign mul_done    = (ph == 0);
    assign mul_lsb_out = ((ph == 10) && !stuck) || spur_lsb;
    assign mul_msb_out = ((ph == 11) && !stuck) || spur_msb;
    assign mul_result  = (ph == 10) ? mp[7:0] :
                         (ph == 11) ? mp[15:8] : spur_res;

    mult_scheduler #(
        .NUM_REQ    (N),
        .DATA_WIDTH (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .req_valid   (vld),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_lsb_out (mul_lsb_out),
        .mul_msb_out (mul_msb_out),
        .mul_result  (mul_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // mode 0: full job, 1: reset at T+5, 2: multiplier never strobes.
    // Entered and left just after a rising edge.
    task automatic job(input int mode, input int bp, input bit spur);
        int w, k, kend;
        bit got;
        logic [31:0] ea, eb, ep;
        rsp_ready = (bp == 0);
        got = 1'b0;
        for (k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            chk("rsp_quiet", 32'(rsp_valid), 0);
            if (req_ready != '0) got = 1'b1;
            else nxt();
        end
        chk("grant_seen", 32'(got), 1);
        if (!got) return;
        w = pick(vld, rr);
        chk("grant_onehot", 32'(req_ready), 32'(1) << w);
        if (exp_gap > 0) chk("grant_gap", 32'(cyc_n - last_grant), 32'(exp_gap));
        last_grant = cyc_n;
        ea = 32'(opa[w]);
        eb = 32'(opb[w]);
        ep = ea * eb;
        rr = (w + 1) % N;
        nxt();
        if (refill) begin
            opa[w] = 8'($urandom_range(0, 255));
            opb[w] = 8'($urandom_range(0, 255));
        end else begin
            vld[w] = 1'b0;
        end
        @(negedge clk);
        chk("start_a", 32'(mul_start), 1);
        chk("data_a", 32'(mul_data), ea);
        chk("ready_pulse", 32'(req_ready), 0);
        nxt();
        @(negedge clk);
        chk("start_off", 32'(mul_start), 0);
        chk("data_b", 32'(mul_data), eb);
        kend = (mode == 1) ? 6 : (mode == 2) ? 18 : 12;
        for (k = 3; k <= kend; k++) begin
            nxt();
            if (mode == 1) i_rst = (k == 5);
            if (spur) begin
                spur_msb = (k == 5);
                spur_lsb = (k == 12);
            end
            @(negedge clk);
            chk("busy_no_rsp", 32'(rsp_valid), 0);
            if (mode == 2) chk("wd_no_grant", 32'(req_ready), 0);
        end
        if (mode == 1) begin
            rr = 0;
            chk("rst_start", 32'(mul_start), 0);
            chk("rst_data", 32'(mul_data), 0);
            chk("rst_prod", 32'(rsp_product), 0);
            chk("rst_id", 32'(rsp_id), 0);
        end
        if (mode != 0) begin
            nxt();
            return;
        end
        for (k = 0; k <= bp; k++) begin
            nxt();
            if (spur) begin
                spur_lsb = 1'b1;
                spur_msb = 1'b1;
            end
            if (k == bp) rsp_ready = 1'b1;
            @(negedge clk);
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(w));
            chk("rsp_product", 32'(rsp_product), ep);
            chk("rsp_no_grant", 32'(req_ready), 0);
            chk("rsp_no_start", 32'(mul_start), 0);
        end
        nxt();
        spur_lsb = 1'b0;
        spur_msb = 1'b0;
    endtask

    initial begin
        logic [N-1:0] nv;
        i_rst = 1'b1;
        rsp_ready = 1'b0;
        stuck = 1'b0;
        spur_lsb = 1'b0;
        spur_msb = 1'b0;
        refill = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 8'd0;
            opb[i] = 8'd0;
        end
        vld = 4'hF;
        repeat (3) nxt();
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_product", 32'(rsp_product), 0);
        chk("reset_start", 32'(mul_start), 0);
        chk("reset_data", 32'(mul_data), 0);
        nxt();
        i_rst = 1'b0;
        vld = '0;

        // single request
        opa[0] = 8'd13;
        opb[0] = 8'd11;
        vld[0] = 1'b1;
        exp_gap = 0;
        job(0, 0, 0);

        // corners back to back on requester 2
        opa[2] = 8'd255; opb[2] = 8'd255; vld[2] = 1'b1;
        exp_gap = 14;
        job(0, 0, 0);
        opa[2] = 8'd0; opb[2] = 8'd200; vld[2] = 1'b1;
        job(0, 0, 0);
        opa[2] = 8'd1; opb[2] = 8'd255; vld[2] = 1'b1;
        job(0, 0, 0);

        // all requesters continuously valid from a fresh pointer
        i_rst = 1'b1;
        nxt();
        i_rst = 1'b0;
        rr = 0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 8'($urandom_range(0, 255));
            opb[i] = 8'($urandom_range(0, 255));
        end
        vld = 4'hF;
        refill = 1'b1;
        exp_gap = 0;
        job(0, 0, 0);
        exp_gap = 14;
        repeat (4) job(0, 0, 0);
        refill = 1'b0;
        vld = '0;

        // random arrivals and random backpressure
        exp_gap = 0;
        repeat (8) begin
            nv = 4'($urandom_range(0, 15));
            if ((vld | nv) == '0) nv = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && nv[i]) begin
                    opa[i] = 8'($urandom_range(0, 255));
                    opb[i] = 8'($urandom_range(0, 255));
                    vld[i] = 1'b1;
                end
            end
            job(0, $urandom_range(0, 3), 0);
        end
        vld = '0;

        // backpressure with stray strobes, another request pending
        opa[1] = 8'($urandom_range(16, 255)); opb[1] = 8'($urandom_range(16, 255));
        opa[3] = 8'($urandom_range(0, 255)); opb[3] = 8'($urandom_range(0, 255));
        vld = 4'b1010;
        exp_gap = 0;
        job(0, 5, 1);
        exp_gap = 19;
        job(0, 0, 0);

        // reset while the multiplier is busy, then 7 x 9
        opa[3] = 8'($urandom_range(0, 255)); opb[3] = 8'($urandom_range(0, 255));
        vld = 4'b1000;
        exp_gap = 0;
        job(1, 0, 0);
        opa[1] = 8'd7;
        opb[1] = 8'd9;
        vld = 4'b0010;
        exp_gap = 13;
        job(0, 0, 0);

        // multiplier that never strobes; second request must wait it out
        opa[0] = 8'($urandom_range(0, 255)); opb[0] = 8'($urandom_range(0, 255));
        opa[2] = 8'($urandom_range(0, 255)); opb[2] = 8'($urandom_range(0, 255));
        vld = 4'b0101;
        stuck = 1'b1;
        exp_gap = 14;
        job(2, 0, 0);
        stuck = 1'b0;
        exp_gap = 19;
        job(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not complete");
    end

endmodule
